// File: rtl/program_end_dumper.sv
// ---------------------------------------------------------------------------
// ProgramEndDumper
//
// Purpose:
//   Sits behind the end-of-program detector. While the program runs it counts
//   cycles. When programEnd is seen it freezes the pipeline and streams a
//   snapshot byte by byte over a valid/ready link to the debug UART:
//     HEADER, run-cycle count (4 bytes, MSB first),
//     then every register-file word (4 bytes each, MSB first).
//   After the last byte it pulses clear_program_finished. It releases the
//   pipeline once the detector has dropped programEnd.
//
// Ports:
//   pipeClk                 in   clock
//   reset                   in   asynchronous reset, active low
//   programEnd              in   level flag from the end-of-program detector
//   reg_rd_addr     [4:0]   out  register-file debug read address
//   reg_rd_data     [31:0]  in   register-file data, valid 1 cycle after addr
//   tx_data         [7:0]   out  byte to transmit
//   tx_valid                out  tx_data is valid
//   tx_ready                in   downstream accepts the byte this edge
//   pipe_stall              out  freezes the pipeline while high
//   clear_program_finished  out  one-cycle pulse clearing the detector
//   dump_busy               out  high whenever the block is not idle
//
// The count goes out as exactly 4 bytes, so CNT_W has to stay at 32.
// reg_rd_addr is 5 bits wide, so NUM_REGS can be at most 32.
// ---------------------------------------------------------------------------
module program_end_dumper #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int          CNT_W    = 32
) (
    input  logic        pipeClk,
    input  logic        reset,
    input  logic        programEnd,
    output logic [4:0]  reg_rd_addr,
    input  logic [31:0] reg_rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        pipe_stall,
    output logic        clear_program_finished,
    output logic        dump_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CYCLES,
        ST_REG_REQ,
        ST_REG_WAIT,
        ST_REG_SEND,
        ST_DONE,
        ST_WAIT_CLR
    } dumpState_t;

    dumpState_t       r_state;
    dumpState_t       w_nextState;
    logic [CNT_W-1:0] r_runCount;
    logic [31:0]      r_shift;
    logic [1:0]       r_byteIdx;
    logic [4:0]       r_index;
    logic             w_lastByte;
    logic             w_lastReg;

    assign w_lastByte = (r_byteIdx == 2'd3);
    assign w_lastReg  = (r_index == 5'(NUM_REGS - 1));

    // Every output is zero in IDLE, so the async reset of the state register
    // alone is enough to clear them immediately.
    assign pipe_stall  = (r_state != ST_IDLE);
    assign dump_busy   = (r_state != ST_IDLE);
    assign reg_rd_addr = r_index;

    // State register.
    always_ff @(posedge pipeClk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and transmit outputs. Every byte field is held on tx_data
    // until tx_ready accepts it, so tx_ready alone decides when to advance.
    always_comb begin
        w_nextState            = r_state;
        tx_valid               = 1'b0;
        tx_data                = 8'h00;
        clear_program_finished = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (programEnd) begin
                    w_nextState = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    w_nextState = ST_CYCLES;
                end
            end
            ST_CYCLES: begin
                tx_valid = 1'b1;
                tx_data  = r_shift[31:24];
                if (tx_ready && w_lastByte) begin
                    w_nextState = ST_REG_REQ;
                end
            end
            ST_REG_REQ: begin
                w_nextState = ST_REG_WAIT;
            end
            ST_REG_WAIT: begin
                w_nextState = ST_REG_SEND;
            end
            ST_REG_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_shift[31:24];
                if (tx_ready && w_lastByte) begin
                    w_nextState = w_lastReg ? ST_DONE : ST_REG_REQ;
                end
            end
            ST_DONE: begin
                clear_program_finished = 1'b1;
                w_nextState            = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (!programEnd) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath. The count and each register word share one shift register:
    // the top byte is always the one on the wire, and it shifts left on each
    // accepted byte. The byte index wraps 3 -> 0 by itself at the field end.
    always_ff @(posedge pipeClk or negedge reset) begin
        if (!reset) begin
            r_runCount <= '0;
            r_shift    <= '0;
            r_byteIdx  <= '0;
            r_index    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (programEnd) begin
                        r_shift   <= r_runCount;
                        r_byteIdx <= '0;
                    end else if (r_runCount != '1) begin
                        r_runCount <= r_runCount + 1'b1;
                    end
                end
                ST_CYCLES: begin
                    if (tx_ready) begin
                        r_shift   <= {r_shift[23:0], 8'h00};
                        r_byteIdx <= r_byteIdx + 2'd1;
                        if (w_lastByte) begin
                            r_index <= '0;
                        end
                    end
                end
                ST_REG_WAIT: begin
                    r_shift   <= reg_rd_data;
                    r_byteIdx <= '0;
                end
                ST_REG_SEND: begin
                    if (tx_ready) begin
                        r_shift   <= {r_shift[23:0], 8'h00};
                        r_byteIdx <= r_byteIdx + 2'd1;
                        if (w_lastByte && !w_lastReg) begin
                            r_index <= r_index + 5'd1;
                        end
                    end
                end
                ST_WAIT_CLR: begin
                    if (!programEnd) begin
                        r_runCount <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_end_dumper.sv
// ---------------------------------------------------------------------------
// tb_program_end_dumper
//
// Drives program_end_dumper through several complete dumps, an aborted dump
// and a saturated counter. A small register file with one cycle of read
// latency feeds the debug read port. For every dump the expected byte stream
// is assembled from the register contents and the expected cycle count.
// ---------------------------------------------------------------------------
module tb_program_end_dumper;

    logic        pipeClk;
    logic        reset;
    logic        programEnd;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pipe_stall;
    logic        clear_program_finished;
    logic        dump_busy;

    logic [31:0] regFile [32];
    logic [7:0]  expQ [$];
    int          errors = 0;
    int          checks = 0;

    program_end_dumper dut (
        .pipeClk                (pipeClk),
        .reset                  (reset),
        .programEnd             (programEnd),
        .reg_rd_addr            (reg_rd_addr),
        .reg_rd_data            (reg_rd_data),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .pipe_stall             (pipe_stall),
        .clear_program_finished (clear_program_finished),
        .dump_busy              (dump_busy)
    );

    initial begin
        pipeClk = 1'b0;
        forever #5 pipeClk = ~pipeClk;
    end

    // Register file with one cycle of read latency.
    always @(posedge pipeClk) begin
        reg_rd_data <= regFile[reg_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The whole snapshot as it should appear on the wire.
    task automatic buildExpected(input logic [31:0] count);
        expQ.delete();
        expQ.push_back(8'hA5);
        for (int b = 3; b >= 0; b--) expQ.push_back(count[b*8 +: 8]);
        for (int i = 0; i < 32; i++) begin
            for (int b = 3; b >= 0; b--) expQ.push_back(regFile[i][b*8 +: 8]);
        end
    endtask

    // Called at a negedge with the DUT already presenting the header. Picks
    // tx_ready each cycle, checks every accepted byte against expQ and checks
    // that a stalled byte is held. Returns at the negedge that shows the
    // clear pulse, or just after the abortAfter-th byte has been accepted.
    task automatic applyStimulus(input bit randomReady, input int dropAt, input int abortAfter);
        int         sent = 0;
        bit         sawPulse = 0;
        bit         prevHold = 0;
        bit         readyNow;
        logic [7:0] prevData = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prevHold) begin
                checkOutput("holdValid", 32'(tx_valid), 32'd1);
                checkOutput("holdData", 32'(tx_data), 32'(prevData));
            end
            if (clear_program_finished) begin
                sawPulse = 1;
                checkOutput("bytesAtPulse", sent, 133);
                checkOutput("validAtPulse", 32'(tx_valid), 32'd0);
                break;
            end
            readyNow = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = readyNow;
            prevHold = tx_valid && !readyNow;
            prevData = tx_data;
            if (tx_valid && readyNow) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraByte", sent + 1, 133);
                end else begin
                    checkOutput($sformatf("byte%0d", sent), 32'(tx_data), 32'(expQ.pop_front()));
                end
                sent++;
                if (sent == dropAt) programEnd = 1'b0;
                if (sent == abortAfter) return;
            end
            @(negedge pipeClk);
        end
        if (abortAfter < 0) checkOutput("dumpDone", 32'(sawPulse), 32'd1);
    endtask

    // Raise programEnd after idleCycles counting edges and check the header
    // comes up on the very next edge.
    task automatic startDump(input int idleCycles);
        repeat (idleCycles) @(negedge pipeClk);
        programEnd = 1'b1;
        @(negedge pipeClk);
        checkOutput("stallRise", 32'(pipe_stall), 32'd1);
        checkOutput("busyRise", 32'(dump_busy), 32'd1);
        checkOutput("headerValid", 32'(tx_valid), 32'd1);
        checkOutput("headerData", 32'(tx_data), 32'hA5);
    endtask

    initial begin
        logic [63:0] satCount;
        reset      = 1'b0;
        programEnd = 1'b0;
        tx_ready   = 1'b0;
        for (int i = 0; i < 32; i++) regFile[i] = $urandom;

        #2;
        checkOutput("rstValid", 32'(tx_valid), 32'd0);
        checkOutput("rstStall", 32'(pipe_stall), 32'd0);
        checkOutput("rstBusy", 32'(dump_busy), 32'd0);
        checkOutput("rstClear", 32'(clear_program_finished), 32'd0);
        checkOutput("rstAddr", 32'(reg_rd_addr), 32'd0);
        repeat (2) @(negedge pipeClk);
        reset = 1'b1;

        // Dump 1: 100 run cycles, tx_ready always high.
        $display("[TB] dump with tx_ready held high");
        startDump(100);
        buildExpected(32'd100);
        applyStimulus(1'b0, -1, -1);
        for (int k = 0; k < 5; k++) begin
            @(negedge pipeClk);
            checkOutput("clearOnce", 32'(clear_program_finished), 32'd0);
            checkOutput("waitClrStall", 32'(pipe_stall), 32'd1);
        end
        programEnd = 1'b0;
        @(negedge pipeClk);
        checkOutput("idleStall", 32'(pipe_stall), 32'd0);
        checkOutput("idleBusy", 32'(dump_busy), 32'd0);

        // Dump 2: same count and registers, random tx_ready, programEnd
        // dropped mid-dump.
        $display("[TB] dump with random tx_ready");
        startDump(100);
        buildExpected(32'd100);
        applyStimulus(1'b1, 20, -1);
        @(negedge pipeClk);
        checkOutput("clearOnce2", 32'(clear_program_finished), 32'd0);
        checkOutput("waitClrStall2", 32'(pipe_stall), 32'd1);
        @(negedge pipeClk);
        checkOutput("idleStall2", 32'(pipe_stall), 32'd0);

        // Dump 3: reset after 40 bytes, then a full restart with count 0.
        $display("[TB] reset in the middle of a dump");
        startDump(7);
        buildExpected(32'd7);
        applyStimulus(1'b1, -1, 40);
        #1 reset = 1'b0;
        #1;
        checkOutput("abortValid", 32'(tx_valid), 32'd0);
        checkOutput("abortStall", 32'(pipe_stall), 32'd0);
        checkOutput("abortBusy", 32'(dump_busy), 32'd0);
        checkOutput("abortClear", 32'(clear_program_finished), 32'd0);
        for (int i = 0; i < 32; i++) regFile[i] = 32'h0102_0300 + 32'(i);
        @(negedge pipeClk);
        reset = 1'b1;
        @(negedge pipeClk);
        checkOutput("restartValid", 32'(tx_valid), 32'd1);
        checkOutput("restartData", 32'(tx_data), 32'hA5);
        buildExpected(32'd0);
        applyStimulus(1'b0, -1, -1);
        @(negedge pipeClk);
        checkOutput("clearOnce3", 32'(clear_program_finished), 32'd0);
        programEnd = 1'b0;
        @(negedge pipeClk);
        checkOutput("idleBusy3", 32'(dump_busy), 32'd0);

        // Dump 4: counter pushed close to the top, must saturate.
        $display("[TB] saturated run counter");
        force dut.r_runCount = 32'hFFFF_FFFD;
        @(negedge pipeClk);
        release dut.r_runCount;
        satCount = 64'hFFFF_FFFD + 64'd5;
        if (satCount > 64'hFFFF_FFFF) satCount = 64'hFFFF_FFFF;
        startDump(5);
        buildExpected(satCount[31:0]);
        applyStimulus(1'b1, -1, -1);
        programEnd = 1'b0;
        repeat (2) @(negedge pipeClk);
        checkOutput("finalIdle", 32'(dump_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_end_dumper.md
Name: program_end_dumper

Overview:
- Sits directly downstream of the end-of-program detector and consumes its programEnd flag.
- On programEnd it freezes the pipeline and streams a snapshot over a byte-wide valid/ready transmit interface feeding the debug UART.
- The snapshot contains a header, the program's run-cycle count and all register-file words.
- When the stream completes it pulses clear_program_finished back to the detector and releases the pipeline.

Parameters:
- NUM_REGS, 32, number of register-file words dumped (addresses 0..NUM_REGS-1).
- HEADER, 8'hA5, first byte of every dump.
- CNT_W, 32, run-cycle counter width; sent as 4 bytes, so CNT_W must be 32.

Ports:
- pipeClk  input  1  single clock for the block.
- reset  input  1  asynchronous, active-low reset (block in reset while reset==0).
- programEnd  input  1  level flag from the end-of-program detector.
- reg_rd_addr  output  5  register-file debug read address.
- reg_rd_data  input  32  register-file read data, valid 1 cycle after reg_rd_addr.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  downstream accepts the byte.
- pipe_stall  output  1  freezes the pipeline while high.
- clear_program_finished  output  1  one-cycle pulse to clear the detector.
- dump_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset==0) forces all outputs to 0 immediately, state to IDLE and run counter to 0. This also applies mid-dump: the partial stream is abandoned and there is no resume.
- States:
  - IDLE: run counter increments each cycle while programEnd==0 and saturates at all-ones, no wrap. If programEnd==1 at a clock edge, latch the counter, go to HEADER; pipe_stall and dump_busy rise on that edge.
  - HEADER: send HEADER, then go to CYCLES.
  - CYCLES: send the latched count as 4 bytes, MSB first, then set index=0 and go to REG_REQ.
  - REG_REQ: drive reg_rd_addr=index, go to REG_WAIT.
  - REG_WAIT: capture reg_rd_data into a 32-bit shift register, go to REG_SEND.
  - REG_SEND: send 4 bytes MSB first. If index==NUM_REGS-1, go to DONE; else index+1 and go to REG_REQ.
  - DONE: clear_program_finished=1 for exactly one cycle, then go to WAIT_CLR.
  - WAIT_CLR: stay until programEnd==0, then go to IDLE and clear the run counter. pipe_stall and dump_busy fall on the IDLE entry edge.
- Transmit handshake:
  - A byte transfers on a clock edge where tx_valid and tx_ready are both 1.
  - tx_data stays stable and tx_valid stays high until the transfer; tx_valid never drops without a transfer.
  - After a transfer the next byte of the same field is presented the following cycle, giving back-to-back bytes when tx_ready is held high.
  - tx_valid is 0 in REG_REQ, REG_WAIT, DONE, WAIT_CLR and IDLE.
- Stream length: 1 + 4 + 4*NUM_REGS bytes, 133 bytes at the defaults.
- Latency: with tx_ready held at 1, the HEADER byte transfers 1 cycle after programEnd is sampled.
- programEnd dropping mid-dump is ignored; the dump always completes. A new dump needs programEnd high again while in IDLE.
- The reg_rd_addr width is fixed at 5, so NUM_REGS must be ≤32.

Test Plan:
- Reset, hold programEnd=0 for 100 cycles, then raise it with tx_ready=1 -> pipe_stall rises on the next edge; bytes are A5,00,00,00,64 (count 100), then 128 register bytes MSB first matching a preloaded register model; 133 transfers total, then a single clear_program_finished pulse.
- Toggle tx_ready randomly (≈50%) during a dump -> tx_data is never changed while tx_valid=1 and tx_ready=0; byte sequence is identical to the tx_ready=1 case.
- Keep programEnd high for 5 cycles after the clear pulse -> block stays in WAIT_CLR with pipe_stall=1; it returns to IDLE and pipe_stall=0 one edge after programEnd=0.
- Assert reset=0 mid-dump (after ~40 bytes) -> tx_valid, pipe_stall, dump_busy and clear_program_finished go to 0 without a clock edge. After release with programEnd=1, a full dump restarts with the A5 header and count 0.
- Preload the counter to near saturation (force) and run -> count sent as FF,FF,FF,FF with no wrap.
- Register model with reg[i]=32'h0102_0300+i -> register i bytes 01,02,03,i, confirming the 1-cycle read latency and the REG_REQ/REG_WAIT addressing.
